// File: rtl/prog_int_ctrl.sv
// prog_int_ctrl: programmable interrupt controller with fully nested priority,
// optional rotation, auto-EOI and a two-pulse acknowledge/vector handshake.
module prog_int_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               we,
    input  logic               re,
    input  logic [2:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic               inta,
    output logic               int_out,
    output logic [VEC_W-1:0]   vec_out,
    output logic               vec_valid
);
    localparam int IDX_W = $clog2(NUM_IRQ);
    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;
    state_t state, state_nx;
    logic [NUM_IRQ-1:0] mask, trig, irr_e, isr, irq_q, cur_bit;
    logic [NUM_IRQ-1:0] irr_eff, req, req_e, eoi_bit, isr_e, ack_bit, ack_set, auto_bit;
    logic [VEC_W-1:0] vbase;
    logic [1:0] ctrl;
    logic [IDX_W-1:0] low_ptr, cur_idx, spec_idx, ns_idx, lp_e, ack_idx;
    logic rot, eoi, ack_ok, int_nx, do_ack, do_vec, unused;
    logic [31:0] rd_nx;
    int ns_r, ack_r;

    // rank 0 is the highest priority; in rotate mode channel low_ptr+1 gets rank 0
    function automatic int rank(input int i, input int lp, input logic rt);
        int r;
        r = i + NUM_IRQ - 1 - lp;
        return rt ? (r >= NUM_IRQ ? r - NUM_IRQ : r) : i;
    endfunction

    function automatic int top(input logic [NUM_IRQ-1:0] v, input int lp, input logic rt);
        int best;
        best = NUM_IRQ;
        for (int i = 0; i < NUM_IRQ; i++)
            if (v[i] && rank(i, lp, rt) < best) best = rank(i, lp, rt);
        return best;
    endfunction

    function automatic logic [IDX_W-1:0] chan(input int r, input int lp, input logic rt);
        int c;
        c = r + lp + 1;
        return IDX_W'(rt ? (c >= NUM_IRQ ? c - NUM_IRQ : c) : r);
    endfunction

    assign rot = ctrl[0];
    assign eoi = we && addr == 3'd4;
    assign spec_idx = wdata[IDX_W-1:0];
    assign irr_eff = (trig & irq_q & ~isr) | irr_e;
    assign req = irr_eff & ~mask;
    assign unused = ^wdata;

    // An EOI in the same cycle as an ack is applied first, so the ack sees isr_e/lp_e
    always_comb begin
        ns_r = top(isr, int'(low_ptr), rot);
        ns_idx = chan(ns_r, int'(low_ptr), rot);
        eoi_bit = !eoi ? '0 : wdata[8] ? (NUM_IRQ'(1) << spec_idx) & isr : (|isr ? NUM_IRQ'(1) << ns_idx : '0);
        isr_e = isr & ~eoi_bit;
        lp_e = (rot && |eoi_bit) ? (wdata[8] ? spec_idx : ns_idx) : low_ptr;
        req_e = ((trig & irq_q & ~isr_e) | irr_e) & ~mask;
        ack_r = top(req_e, int'(lp_e), rot);
        ack_ok = ack_r < top(isr_e, int'(lp_e), rot);
        ack_idx = ack_ok ? chan(ack_r, int'(lp_e), rot) : IDX_W'(NUM_IRQ - 1);
        ack_bit = ack_ok ? NUM_IRQ'(1) << ack_idx : '0;
    end

    always_ff @(posedge clk)
        state <= !reset_n ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (inta) state_nx = ACK1;
            ACK1:    if (inta) state_nx = ACK2;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        do_ack = state == IDLE && inta;
        do_vec = state == ACK1 && inta;
        int_nx = state == IDLE && !inta && top(req, int'(low_ptr), rot) < top(isr, int'(low_ptr), rot);
        ack_set = do_ack ? ack_bit : '0;
        auto_bit = do_vec && ctrl[1] ? isr_e & cur_bit : '0;
    end

    always_comb begin
        case (addr)
            3'd0:    rd_nx = 32'(mask);
            3'd1:    rd_nx = 32'(trig);
            3'd2:    rd_nx = 32'(vbase);
            3'd3:    rd_nx = 32'(ctrl);
            3'd5:    rd_nx = 32'(irr_eff);
            3'd6:    rd_nx = 32'(isr);
            default: rd_nx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask      <= '1;
            trig      <= '0;
            vbase     <= '0;
            ctrl      <= '0;
            irr_e     <= '0;
            isr       <= '0;
            irq_q     <= '0;
            low_ptr   <= IDX_W'(NUM_IRQ - 1);
            cur_idx   <= '0;
            cur_bit   <= '0;
            int_out   <= 1'b0;
            vec_out   <= '0;
            vec_valid <= 1'b0;
            rdata     <= '0;
        end else begin
            irq_q     <= irq;
            irr_e     <= ((irr_e & ~ack_set) | (irq & ~irq_q)) & ~trig;
            isr       <= (isr_e & ~auto_bit) | ack_set;
            low_ptr   <= (rot && |auto_bit) ? cur_idx : lp_e;
            int_out   <= int_nx;
            vec_valid <= do_vec;
            if (do_ack) begin
                cur_idx <= ack_idx;
                cur_bit <= ack_bit;
            end
            if (do_vec) vec_out <= vbase + VEC_W'(cur_idx);
            if (re) rdata <= rd_nx;
            if (we && addr == 3'd0) mask <= wdata[NUM_IRQ-1:0];
            if (we && addr == 3'd1) trig <= wdata[NUM_IRQ-1:0];
            if (we && addr == 3'd2) vbase <= wdata[VEC_W-1:0];
            if (we && addr == 3'd3) ctrl <= wdata[1:0];
        end
    end
endmodule
